// File: rtl/sr_mem_ctrl_pipe.sv
// Data-memory controller for the SR CPU: byte/half/word loads and stores on a word-organised RAM.
// Latency: loads respond LATENCY cycles after the request cycle; stores commit on the acceptance edge.
// Backpressure: req_ready drops while a load is outstanding and rises again in its response cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_op                OP_LOAD / OP_STORE; any other code is accepted and ignored
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_addr              byte address (word index [AW+1:2], lane [1:0])
//   req_wdata             right-aligned store data
//   rsp_valid             one-cycle response pulse
//   rsp_data              load result, all ones when no response is presented
//   rsp_err               response is an error (out-of-range, misaligned, illegal size)
module sr_mem_ctrl_pipe #(
  parameter int         DEPTH          = 64,
  parameter int         LATENCY        = 1,
  parameter int         CLEAR_ON_RESET = 1,
  parameter logic [2:0] OP_LOAD        = 3'd1,
  parameter logic [2:0] OP_STORE       = 3'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        init_q, init_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        pend_err_q, pend_err_d;
  logic [31:0] pend_data_q, pend_data_d;

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          err_oor;
  logic          err_mis;
  logic          err_size;
  logic          req_err;
  logic          accept;
  logic          do_load;
  logic          do_store;
  logic          wr_en;
  logic [31:0]   wr_mask;
  logic [31:0]   wr_dat;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_res;
  logic [31:0]   ld_out;

  logic [31:0]   ram_rd [DEPTH];

  // Ready is held low until the first edge after reset release so that no
  // request can be taken while the RAM clear is still being applied.
  assign req_ready = init_q & (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign do_load   = accept & (req_op == OP_LOAD);
  assign do_store  = accept & (req_op == OP_STORE);

  // Request decode and error detection
  always_comb begin
    word_idx = req_addr[AW+1:2];
    lane     = req_addr[1:0];
    // Any address bit above the RAM window is an error, never an alias.
    err_oor  = |(req_addr >> (AW + 2));
    err_mis  = ((req_size == SZ_HALF) & req_addr[0]) |
               ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
    err_size = (req_size == 2'b11);
    req_err  = err_oor | err_mis | err_size;
  end

  // Store lane mask and lane-replicated write data
  always_comb begin
    wr_en   = do_store & ~req_err;
    wr_mask = 32'hFFFF_FFFF;
    wr_dat  = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        wr_mask = 32'h0000_00FF << {lane, 3'b000};
        wr_dat  = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        wr_mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wr_dat  = {2{req_wdata[15:0]}};
      end
      default: begin
        wr_mask = 32'hFFFF_FFFF;
        wr_dat  = req_wdata;
      end
    endcase
  end

  // Load lane select and extension
  always_comb begin
    rd_word  = ram_rd[word_idx];
    rd_shift = rd_word >> {lane, 3'b000};
    byte_v   = rd_shift[7:0];
    half_v   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_size)
      SZ_BYTE: ld_res = {{24{~req_unsigned & byte_v[7]}}, byte_v};
      SZ_HALF: ld_res = {{16{~req_unsigned & half_v[15]}}, half_v};
      default: ld_res = rd_word;
    endcase
    ld_out = req_err ? 32'hFFFF_FFFF : ld_res;
  end

  // RAM words: each word merges the masked store data into its old contents.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [31:0] mem_q;
    logic        hit;

    assign hit       = wr_en & (word_idx == AW'(g));
    assign ram_rd[g] = mem_q;

    if (CLEAR_ON_RESET != 0) begin : g_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q <= '0;
        end else if (hit) begin
          mem_q <= (mem_q & ~wr_mask) | (wr_dat & wr_mask);
        end
      end
    end else begin : g_keep
      always_ff @(posedge clk) begin
        if (hit) begin
          mem_q <= (mem_q & ~wr_mask) | (wr_dat & wr_mask);
        end
      end
    end
  end

  // FSM next-state and response generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_d      = 1'b1;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = 32'hFFFF_FFFF;
    pend_err_d  = pend_err_q;
    pend_data_d = pend_data_q;

    case (state_q)
      S_IDLE: begin
        if (do_load) begin
          if (LATENCY == 1) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_data_d  = ld_out;
          end else begin
            // Read data is captured now, so a later store cannot change
            // what this load returns.
            state_d     = S_WAIT;
            cnt_d       = CNT_INIT;
            pend_err_d  = req_err;
            pend_data_d = ld_out;
          end
        end else if (do_store & req_err) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pend_err_q;
          rsp_data_d  = pend_data_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      init_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'hFFFF_FFFF;
      pend_err_q  <= 1'b0;
      pend_data_q <= 32'hFFFF_FFFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_q      <= init_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      pend_err_q  <= pend_err_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sr_mem_ctrl_pipe.sv
// Bench for sr_mem_ctrl_pipe: random and directed loads/stores against a word-array model.
// Latency: responses are sampled on falling edges and timed in cycles after acceptance.
// Backpressure: requests are held until req_ready is seen high.
module tb_sr_mem_ctrl_pipe;

  localparam int         DEPTH = 64;
  localparam int         LAT   = 3;
  localparam int         CLR   = 1;
  localparam logic [2:0] OPL   = 3'd1;
  localparam logic [2:0] OPS   = 3'd2;
  localparam logic [2:0] OPN   = 3'd0;
  localparam int         WIN   = LAT + 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];

  sr_mem_ctrl_pipe #(
    .DEPTH(DEPTH), .LATENCY(LAT), .CLEAR_ON_RESET(CLR), .OP_LOAD(OPL), .OP_STORE(OPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_err(input logic [1:0] size, input logic [31:0] addr);
    if (addr >= 32'(DEPTH * 4)) return 1'b1;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (addr % 32'd2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 32'd4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] v;
    int off;
    w   = model[int'(addr / 32'd4)];
    off = int'(addr % 32'd4);
    if (size == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void m_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] mask;
    int idx;
    int off;
    idx = int'(addr / 32'd4);
    off = int'(addr % 32'd4);
    if (size == 2'd0)      mask = 32'hFF << (8 * off);
    else if (size == 2'd1) mask = 32'hFFFF << (8 * off);
    else                   mask = 32'hFFFF_FFFF;
    model[idx] = (model[idx] & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  function automatic void m_reset();
    if (CLR != 0) begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic [2:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_op       = op;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  task automatic release_req();
    req_valid = 1'b0;
    req_op    = OPN;
  endtask

  // Holds the request until it is accepted; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    bit ok;
    ok = 1'b0;
    drive(op, size, uns, addr, wd);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
    else begin
      errors++;
      $display("FAIL send_timeout: req_ready stayed low for 50 cycles (addr %h)", addr);
    end
    #1;
    release_req();
  endtask

  // Watches WIN falling edges after acceptance and reports what was seen.
  task automatic collect(output int lat, output int pulses, output logic err,
                         output logic [31:0] data, output int rdy_low, output int idle_bad);
    lat = 0; pulses = 0; err = 1'b0; data = 32'h0; rdy_low = 0; idle_bad = 0;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat  = k;
          err  = rsp_err;
          data = rsp_data;
        end
      end else begin
        if (rsp_err !== 1'b0 || rsp_data !== 32'hFFFF_FFFF) idle_bad++;
        if (lat == 0 && req_ready !== 1'b1) rdy_low++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat, pulses, rdy_low, idle_bad;
    logic err;
    logic [31:0] data;
    rst_n = 1'b0;
    release_req();
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    m_reset();
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", rsp_err); end
    checks++; if (rsp_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_data: got %h want ffffffff", rsp_data); end
    #1 rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b want 1", req_ready); end
    send(OPL, 2'd2, 1'b0, 32'h0FC, 32'h0);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (lat != LAT) begin errors++; $display("FAIL clr_load_lat: got %0d want %0d", lat, LAT); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL clr_load_pulses: got %0d want 1", pulses); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_load_err: got %b want 0", err); end
    checks++; if (data !== m_load(2'd2, 1'b0, 32'h0FC)) begin errors++; $display("FAIL clr_load_data: got %h want %h", data, m_load(2'd2, 1'b0, 32'h0FC)); end
    checks++; if (rdy_low != LAT - 1) begin errors++; $display("FAIL clr_load_ready_low: got %0d want %0d", rdy_low, LAT - 1); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle_outputs: got %0d bad cycles want 0", idle_bad); end
  endtask

  task automatic test_directed();
    int lat, pulses, rdy_low, idle_bad;
    logic err;
    logic [31:0] data;
    send(OPS, 2'd2, 1'b0, 32'h10, 32'h1122_3344); m_store(2'd2, 32'h10, 32'h1122_3344);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (pulses != 0 || rdy_low != 0) begin errors++; $display("FAIL store_quiet: got pulses %0d ready_low %0d want 0 0", pulses, rdy_low); end
    send(OPS, 2'd0, 1'b0, 32'h12, 32'hFFFF_FFAB); m_store(2'd0, 32'h12, 32'hFFFF_FFAB);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    send(OPL, 2'd2, 1'b0, 32'h10, 32'h0);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (data !== 32'h11AB_3344 || err !== 1'b0) begin errors++; $display("FAIL word_after_byte: got %h err %b want 11ab3344 err 0", data, err); end
    send(OPL, 2'd0, 1'b0, 32'h12, 32'h0);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (data !== 32'hFFFF_FFAB) begin errors++; $display("FAIL signed_byte: got %h want ffffffab", data); end
    send(OPL, 2'd1, 1'b1, 32'h12, 32'h0);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (data !== 32'h0000_11AB) begin errors++; $display("FAIL unsigned_half: got %h want 000011ab", data); end
  endtask

  task automatic test_errors();
    int lat, pulses, rdy_low, idle_bad;
    logic err;
    logic [31:0] data;
    send(OPS, 2'd2, 1'b0, 32'h102, 32'hDEAD_BEEF);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (lat != 1 || pulses != 1) begin errors++; $display("FAIL store_err_timing: got lat %0d pulses %0d want 1 1", lat, pulses); end
    checks++; if (err !== 1'b1 || data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL store_err_rsp: got err %b data %h want 1 ffffffff", err, data); end
    send(OPL, 2'd2, 1'b0, 32'h0, 32'h0);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (data !== m_load(2'd2, 1'b0, 32'h0)) begin errors++; $display("FAIL no_alias_write: got %h want %h", data, m_load(2'd2, 1'b0, 32'h0)); end
    send(OPL, 2'd2, 1'b0, 32'h100, 32'h0);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (lat != LAT || err !== 1'b1 || data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL load_oor: got lat %0d err %b data %h want %0d 1 ffffffff", lat, err, data, LAT); end
    send(OPL, 2'd3, 1'b0, 32'h10, 32'h0);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (lat != LAT || err !== 1'b1 || data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL load_bad_size: got lat %0d err %b data %h want %0d 1 ffffffff", lat, err, data, LAT); end
    send(OPL, 2'd1, 1'b0, 32'h11, 32'h0);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (err !== 1'b1 || data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL load_misaligned_half: got err %b data %h want 1 ffffffff", err, data); end
  endtask

  task automatic test_latency();
    int lat, pulses, rdy_low, idle_bad;
    logic err;
    logic [31:0] data;
    logic [31:0] exp1, exp2;
    exp1 = m_load(2'd2, 1'b0, 32'h10);
    exp2 = m_load(2'd0, 1'b1, 32'h13);
    send(OPL, 2'd2, 1'b0, 32'h10, 32'h0);
    drive(OPL, 2'd0, 1'b1, 32'h13, 32'h0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL busy_cycle%0d: got ready %b valid %b want 0 0", k, req_ready, rsp_valid); end
      end else begin
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== exp1) begin errors++; $display("FAIL rsp_cycle: got ready %b valid %b data %h want 1 1 %h", req_ready, rsp_valid, rsp_data, exp1); end
      end
    end
    @(posedge clk);
    #1 release_req();
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (lat != LAT || pulses != 1 || data !== exp2) begin errors++; $display("FAIL second_load: got lat %0d pulses %0d data %h want %0d 1 %h", lat, pulses, data, LAT, exp2); end
  endtask

  task automatic test_back_to_back();
    int lat, pulses, rdy_low, idle_bad;
    logic err;
    logic [31:0] data, wd, a;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a  = 32'h20 + 32'(4 * i);
      wd = $urandom;
      drive(OPS, 2'd2, 1'b0, a, wd);
      m_store(2'd2, a, wd);
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_store%0d: got ready %b valid %b want 1 0", i, req_ready, rsp_valid); end
      @(posedge clk);
      #1;
    end
    release_req();
    for (int i = 0; i < 8; i++) begin
      a = 32'h20 + 32'(4 * i);
      send(OPL, 2'd2, 1'b0, a, 32'h0);
      collect(lat, pulses, err, data, rdy_low, idle_bad);
      checks++; if (data !== m_load(2'd2, 1'b0, a)) begin errors++; $display("FAIL b2b_readback%0d: got %h want %h", i, data, m_load(2'd2, 1'b0, a)); end
    end
  endtask

  task automatic test_reset_mid_load();
    int lat, pulses, rdy_low, idle_bad;
    logic err;
    logic [31:0] data;
    send(OPS, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D); m_store(2'd2, 32'h40, 32'hCAFE_F00D);
    send(OPL, 2'd2, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL async_reset: got valid %b ready %b data %h want 0 0 ffffffff", rsp_valid, req_ready, rsp_data); end
    m_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (pulses != 0) begin errors++; $display("FAIL dropped_load: got %0d pulses want 0", pulses); end
    send(OPL, 2'd2, 1'b0, 32'h40, 32'h0);
    collect(lat, pulses, err, data, rdy_low, idle_bad);
    checks++; if (data !== m_load(2'd2, 1'b0, 32'h40)) begin errors++; $display("FAIL ram_after_reset: got %h want %h", data, m_load(2'd2, 1'b0, 32'h40)); end
  endtask

  task automatic test_random();
    int lat, pulses, rdy_low, idle_bad, r;
    logic err;
    logic [31:0] data, addr, wd, exp_data;
    logic [2:0] op;
    logic [1:0] size;
    logic uns;
    bit exp_err;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = OPL;
      else if (r < 8) op = OPS;
      else begin
        op = 3'($urandom_range(0, 7));
        while (op == OPL || op == OPS) op = 3'($urandom_range(0, 7));
      end
      size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        addr = ($urandom_range(0, 1) == 0) ? 32'(DEPTH * 4) + 32'($urandom_range(0, 4095))
                                           : ($urandom | 32'h8000_0000);
      end else begin
        addr = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
          if (size == 2'd1) addr = addr & ~32'd1;
          if (size == 2'd2) addr = addr & ~32'd3;
        end
      end
      exp_err  = m_err(size, addr);
      exp_data = exp_err ? 32'hFFFF_FFFF : ((op == OPL) ? m_load(size, uns, addr) : 32'hFFFF_FFFF);
      send(op, size, uns, addr, wd);
      collect(lat, pulses, err, data, rdy_low, idle_bad);
      if (op == OPL) begin
        checks++; if (pulses != 1 || lat != LAT) begin errors++; $display("FAIL rnd%0d_load_timing: got pulses %0d lat %0d want 1 %0d", n, pulses, lat, LAT); end
        checks++; if (err !== exp_err || data !== exp_data) begin errors++; $display("FAIL rnd%0d_load addr %h size %0d uns %b: got err %b data %h want %b %h", n, addr, size, uns, err, data, exp_err, exp_data); end
      end else if (op == OPS && exp_err) begin
        checks++; if (pulses != 1 || lat != 1 || err !== 1'b1 || data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rnd%0d_store_err addr %h: got pulses %0d lat %0d err %b data %h want 1 1 1 ffffffff", n, addr, pulses, lat, err, data); end
      end else begin
        if (op == OPS) m_store(size, addr, wd);
        checks++; if (pulses != 0 || rdy_low != 0) begin errors++; $display("FAIL rnd%0d_quiet op %0d: got pulses %0d ready_low %0d want 0 0", n, op, pulses, rdy_low); end
      end
      checks++; if (idle_bad != 0) begin errors++; $display("FAIL rnd%0d_idle: got %0d bad idle cycles want 0", n, idle_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_latency();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
